scroll_ctrl: RTL and testbench

SCROLL_CTRL -- requirements
Module: scroll_ctrl

---
 rtl/dino_pkg.sv | 34 +++
 rtl/edge_det.sv | 43 ++++
 rtl/scroll_ctrl.sv | 135 +++++++++++++
 tb/tb_scroll_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the scrolling/game-state logic and the ground
// renderer: game state encoding, default geometry/speed constants and the
// wrap-around position helper used by every scroll update.
// -----------------------------------------------------------------------------
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_e;

    localparam int GROUND_PERIOD = 160;
    localparam int SPEED_INIT    = 2;
    localparam int SPEED_MAX     = 8;

    // Advance a scroll offset by spd and fold it back into 0..period-1.
    // The sum is taken 11 bits wide so pos + spd can never overflow.
    function automatic logic [9:0] wrap_add(
        input logic [9:0]  pos,
        input logic [3:0]  spd,
        input logic [10:0] period
    );
        logic [10:0] sum;
        sum = {1'b0, pos} + {7'd0, spd};
        if (sum >= period) begin
            return 10'(sum - period);
        end
        return sum[9:0];
    endfunction

endpackage

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Registers a level once and produces a registered one-cycle pulse on the
// selected edge of that level.
//   clk    : clock
//   srst   : synchronous active-high reset
//   sig_i  : level to watch
//   edge_o : one-cycle pulse, one cycle after the edge is sampled
// Parameter RISING selects a 0->1 (1) or 1->0 (0) detector.
// -----------------------------------------------------------------------------
module edge_det #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic sig_i,
    output logic edge_o
);

    logic sig_q;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        pulse_d = RISING ? (sig_i & ~sig_q) : (~sig_i & sig_q);
    end

    // The sampled copy resets to the level that cannot produce an edge on
    // its own: a rising detector pretends the input was already high, so a
    // level held high through reset needs a real low-then-high to fire.
    always_ff @(posedge clk) begin
        if (srst) begin
            sig_q   <= RISING;
            pulse_q <= 1'b0;
        end else begin
            sig_q   <= sig_i;
            pulse_q <= pulse_d;
        end
    end

    assign edge_o = pulse_q;

endmodule

// File: rtl/scroll_ctrl.sv
// -----------------------------------------------------------------------------
// scroll_ctrl
// Game state machine and ground scroller for the runner game. Counts frames
// survived, ramps the scroll speed every RAMP_FRAMES running frames and keeps
// the ground offset wrapped to the ground pattern width.
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   fresh           : frame strobe; a 1->0 transition is a frame boundary
//   start           : debounced start button (level)
//   collision       : dinosaur/obstacle hit (level)
//   game_status     : 1 while running
//   ground_position : scroll offset, 0..GROUND_PERIOD-1
//   speed           : scroll speed in pixels per frame
//   score           : frames survived in the current game (saturating)
//   frame_tick      : one-cycle pulse per detected frame boundary
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module scroll_ctrl #(
    parameter int SPEED_INIT    = dino_pkg::SPEED_INIT,
    parameter int SPEED_MAX     = dino_pkg::SPEED_MAX,
    parameter int RAMP_FRAMES   = 600,
    parameter int GROUND_PERIOD = dino_pkg::GROUND_PERIOD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fresh,
    input  logic        start,
    input  logic        collision,
    output logic        game_status,
    output logic [9:0]  ground_position,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic        frame_tick
);

    import dino_pkg::*;

    localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    game_state_e       state_q, state_d;
    logic              status_q, status_d;
    logic [9:0]        pos_q, pos_d;
    logic [3:0]        speed_q, speed_d;
    logic [15:0]       score_q, score_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    logic              tick;
    logic              start_rise;

    edge_det #(.RISING(1'b0)) u_fresh_fall (
        .clk    (clk),
        .srst   (rst),
        .sig_i  (fresh),
        .edge_o (tick)
    );

    edge_det #(.RISING(1'b1)) u_start_rise (
        .clk    (clk),
        .srst   (rst),
        .sig_i  (start),
        .edge_o (start_rise)
    );

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        speed_d = speed_q;
        score_d = score_q;
        ramp_d  = ramp_q;

        case (state_q)
            IDLE, OVER: begin
                // A collision in OVER is irrelevant: only a start edge moves
                // us, and it always begins a clean game.
                if (start_rise) begin
                    state_d = RUN;
                    pos_d   = '0;
                    speed_d = 4'(SPEED_INIT);
                    score_d = '0;
                    ramp_d  = '0;
                end
            end
            RUN: begin
                // Collision freezes the counters for the cycle it is seen,
                // even if a frame boundary lands on the same cycle.
                if (collision) begin
                    state_d = OVER;
                end else if (tick) begin
                    // Position uses the speed held before this tick's ramp.
                    pos_d = wrap_add(pos_q, speed_q, 11'(GROUND_PERIOD));
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                    if (ramp_q == RAMP_W'(RAMP_FRAMES - 1)) begin
                        ramp_d = '0;
                        if (speed_q < 4'(SPEED_MAX)) begin
                            speed_d = speed_q + 4'd1;
                        end
                    end else begin
                        ramp_d = ramp_q + RAMP_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        status_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= 1'b0;
            pos_q    <= '0;
            speed_q  <= 4'(SPEED_INIT);
            score_q  <= '0;
            ramp_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            pos_q    <= pos_d;
            speed_q  <= speed_d;
            score_q  <= score_d;
            ramp_q   <= ramp_d;
        end
    end

    assign game_status     = status_q;
    assign ground_position = pos_q;
    assign speed           = speed_q;
    assign score           = score_q;
    assign frame_tick      = tick;

endmodule

// File: tb/tb_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scroll_ctrl
// Two instances share one stimulus stream: instance 0 with the default ramp
// period (600 frames), instance 1 with a 4-frame ramp. Stimulus pushes the
// expected outputs of both into a queue; a monitor pops and compares one entry
// on the cycle after each frame_tick and whenever a probe is requested.
// -----------------------------------------------------------------------------
module tb_scroll_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fresh;
    logic        start;
    logic        collision;

    logic        gs [2];
    logic [9:0]  gp [2];
    logic [3:0]  sp [2];
    logic [15:0] sc [2];
    logic        ft [2];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            scroll_ctrl #(
                .SPEED_INIT    (2),
                .SPEED_MAX     (8),
                .RAMP_FRAMES   ((gi == 0) ? 600 : 4),
                .GROUND_PERIOD (160)
            ) u_dut (
                .clk             (clk),
                .rst             (rst),
                .fresh           (fresh),
                .start           (start),
                .collision       (collision),
                .game_status     (gs[gi]),
                .ground_position (gp[gi]),
                .speed           (sp[gi]),
                .score           (sc[gi]),
                .frame_tick      (ft[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic        ft;
        logic        st;
        logic [9:0]  pos;
        logic [3:0]  spd;
        logic [15:0] sc;
    } obs_t;

    typedef struct {
        obs_t  o0;
        obs_t  o1;
        string tag;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    bit   probe_req = 1'b0;

    // Behavioural reference: 0 = idle, 1 = run, 2 = over
    int m_st   [2];
    int m_pos  [2];
    int m_spd  [2];
    int m_sc   [2];
    int m_ramp [2];
    int rf     [2] = '{600, 4};

    function automatic obs_t mk(input int st, input int pos, input int spd, input int scv);
        obs_t o;
        o.ft  = 1'b0;
        o.st  = (st == 1);
        o.pos = 10'(pos);
        o.spd = 4'(spd);
        o.sc  = 16'(scv);
        return o;
    endfunction

    function automatic obs_t model_obs(input int i);
        return mk(m_st[i], m_pos[i], m_spd[i], m_sc[i]);
    endfunction

    task automatic m_clear(input int st);
        for (int i = 0; i < 2; i++) begin
            m_st[i] = st; m_pos[i] = 0; m_spd[i] = 2; m_sc[i] = 0; m_ramp[i] = 0;
        end
    endtask

    task automatic m_tick(input bit coll);
        int sum;
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 1) begin
                if (coll) begin
                    m_st[i] = 2;
                end else begin
                    sum = m_pos[i] + m_spd[i];
                    m_pos[i] = (sum >= 160) ? sum - 160 : sum;
                    if (m_sc[i] < 65535) m_sc[i]++;
                    if (m_ramp[i] == rf[i] - 1) begin
                        m_ramp[i] = 0;
                        if (m_spd[i] < 8) m_spd[i]++;
                    end else begin
                        m_ramp[i]++;
                    end
                end
            end
        end
    endtask

    task automatic push_exp(input obs_t a, input obs_t b, input string tag);
        exp_t e;
        e.o0 = a; e.o1 = b; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic probe_exp(input obs_t a, input obs_t b, input string tag);
        push_exp(a, b, tag);
        probe_req = 1'b1;
        @(negedge clk);
        #1 probe_req = 1'b0;
    endtask

    task automatic probe(input string tag);
        probe_exp(model_obs(0), model_obs(1), tag);
    endtask

    // One frame: fresh high for a cycle, then low; the tick is visible the
    // cycle after fresh is sampled low and acted on at the following edge.
    task automatic frame(input bit coll, input bit do_rst, input string tag);
        @(posedge clk); #1 fresh = 1'b1;
        @(posedge clk); #1 fresh = 1'b0;
        @(posedge clk); #1;
        if (coll) collision = 1'b1;
        if (do_rst) begin
            rst   = 1'b1;
            start = 1'b1;
            m_clear(0);
        end else begin
            m_tick(coll);
        end
        push_exp(model_obs(0), model_obs(1), tag);
        @(posedge clk); #1 collision = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_pulse(input bit coll_too, input string tag);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (coll_too) collision = 1'b1;
        probe({tag, "_pre"});
        @(posedge clk); #1 collision = 1'b0;
        m_clear(1);
        probe(tag);
    endtask

    // Monitor
    initial begin
        bit   ft_prev;
        exp_t e;
        obs_t act;
        obs_t req;
        bit   ok;
        ft_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ft_prev || probe_req) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: output update seen, required none queued");
                end else begin
                    e  = exp_q.pop_front();
                    ok = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        act = {ft[i], gs[i], gp[i], sp[i], sc[i]};
                        req = (i == 0) ? e.o0 : e.o1;
                        n_tests++;
                        if (act !== req) begin
                            n_fail++;
                            ok = 1'b0;
                            $display("FAIL %s dut%0d: got ft=%0d st=%0d pos=%0d spd=%0d score=%0d, required ft=%0d st=%0d pos=%0d spd=%0d score=%0d",
                                     e.tag, i, act.ft, act.st, act.pos, act.spd, act.sc,
                                     req.ft, req.st, req.pos, req.spd, req.sc);
                        end
                    end
                    if (ok) $display("[TB] %s ok: st=%0d pos=%0d/%0d spd=%0d/%0d score=%0d",
                                     e.tag, gs[0], gp[0], gp[1], sp[0], sp[1], sc[0]);
                end
            end
            ft_prev = ft[0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b1; fresh = 1'b0; collision = 1'b0;
        m_clear(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        probe("reset_values");
        repeat (3) @(posedge clk);
        #1;
        probe("start_held_after_reset");
        @(posedge clk); #1 start = 1'b0;

        start_pulse(1'b0, "start");
        for (int k = 1; k <= 80; k++) frame(1'b0, 1'b0, $sformatf("run_tick%0d", k));
        probe_exp(mk(1, 0, 2, 80), model_obs(1), "wrap_after_80");

        frame(1'b1, 1'b0, "collide_on_tick");
        frame(1'b0, 1'b0, "tick_in_over");
        start_pulse(1'b0, "restart");
        for (int k = 1; k <= 30; k++) frame(1'b0, 1'b0, $sformatf("ramp_tick%0d", k));
        probe_exp(mk(1, 60, 2, 30), mk(1, 156, 8, 30), "ramp_after_30");

        @(posedge clk); #1 collision = 1'b1;
        @(posedge clk); #1 collision = 1'b0;
        for (int i = 0; i < 2; i++) m_st[i] = 2;
        probe("collide_no_tick");

        start_pulse(1'b1, "restart_with_collision");
        for (int k = 1; k <= 3; k++) frame(1'b0, 1'b0, $sformatf("post_restart%0d", k));

        frame(1'b0, 1'b1, "reset_on_tick");
        repeat (3) @(posedge clk);
        #1;
        probe("start_held_after_midrun_reset");
        start = 1'b0;
        @(posedge clk); #1;
        start_pulse(1'b0, "restart_after_reset");
        frame(1'b0, 1'b0, "final_tick");

        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
